// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the SRM0 ramp-no-leak neuron column.
package snn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } col_state_t;

  // Width that holds the sum of every weight at full scale.
  function automatic int pot_w(input int num_inputs, input int weight_w);
    return $clog2(num_inputs * (2 ** weight_w - 1) + 1);
  endfunction

  function automatic int w_lsb(input int neuron, input int syn,
                               input int num_inputs, input int weight_w);
    return (neuron * num_inputs + syn) * weight_w;
  endfunction

endpackage

// File: rtl/neuron_body.sv
// One neuron: per-synapse ramp counters, membrane potential and fired flag.
// fire is combinational from the current step's arrivals.
module neuron_body
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int WEIGHT_W   = 3,
  parameter int THRESHOLD  = 8
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [NUM_INPUTS-1:0]          arrived,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
  input  logic                           clear,
  input  logic                           step_en,
  input  logic                           suppress,
  output logic                           fire
);

  localparam int POT_W = pot_w(NUM_INPUTS, WEIGHT_W);
  localparam logic [POT_W:0] TH_EXT = (POT_W + 1)'(THRESHOLD);

  logic [WEIGHT_W-1:0]   ramp [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] contrib;
  logic [POT_W-1:0]      pot;
  logic [POT_W-1:0]      pot_new;
  logic                  fired;

  // A synapse contributes one unit per step until its ramp reaches the weight.
  always_comb begin
    contrib = '0;
    pot_new = pot;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (arrived[i] && (ramp[i] < weights[i*WEIGHT_W +: WEIGHT_W])) begin
        contrib[i] = 1'b1;
        pot_new    = pot_new + POT_W'(1);
      end
    end
  end

  assign fire = step_en && !fired && !suppress && ({1'b0, pot_new} >= TH_EXT);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_INPUTS; i++) ramp[i] <= '0;
      pot   <= '0;
      fired <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_INPUTS; i++) ramp[i] <= '0;
      pot   <= '0;
      fired <= 1'b0;
    end else if (step_en) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (contrib[i]) ramp[i] <= ramp[i] + WEIGHT_W'(1);
      end
      pot <= pot_new;
      if (fire) fired <= 1'b1;
    end
  end

endmodule

// File: rtl/neuron_column_integrator.sv
// Integrates one gamma cycle of temporally coded spikes over a neuron column; one volley
// per step, registered one cycle after in_spikes is sampled; no backpressure, inhibit is sticky.
module neuron_column_integrator
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 8,
  parameter int TIME_PERIOD = 8,
  parameter int WEIGHT_W    = 3,
  parameter int THRESHOLD   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_l,
  input  logic                                      start,
  input  logic [NUM_INPUTS-1:0]                     in_spikes,
  input  logic [NUM_NEURONS*NUM_INPUTS*WEIGHT_W-1:0] weights,
  input  logic                                      inhibit,
  output logic                                      busy,
  output logic                                      volley_valid,
  output logic [NUM_NEURONS-1:0]                    spike_volley,
  output logic [$clog2(TIME_PERIOD):0]              time_val,
  output logic                                      last
);

  localparam int TW   = $clog2(TIME_PERIOD) + 1;
  localparam int NW   = NUM_INPUTS * WEIGHT_W;
  localparam int WTOT = NUM_NEURONS * NW;
  localparam logic [TW-1:0] LAST_STEP = TW'(TIME_PERIOD - 1);

  col_state_t             state;
  col_state_t             state_nxt;
  logic [TW-1:0]          step;
  logic [NUM_INPUTS-1:0]  arrived;
  logic [NUM_INPUTS-1:0]  arrived_now;
  logic                   inh_latch;
  logic [WTOT-1:0]        w_q;
  logic [NUM_NEURONS-1:0] fire;
  logic                   clear;
  logic                   step_en;
  logic                   suppress;
  logic                   final_step;

  assign step_en     = (state == RUN);
  assign clear       = (state == IDLE) && start;
  assign arrived_now = arrived | in_spikes;
  assign suppress    = inhibit | inh_latch;
  assign final_step  = (step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (final_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      w_q          <= '0;
      arrived      <= '0;
      inh_latch    <= 1'b0;
      step         <= '0;
      busy         <= 1'b0;
      volley_valid <= 1'b0;
      spike_volley <= '0;
      time_val     <= '0;
      last         <= 1'b0;
    end else if (clear) begin
      w_q          <= weights;
      arrived      <= '0;
      inh_latch    <= 1'b0;
      step         <= '0;
      busy         <= 1'b1;
      volley_valid <= 1'b0;
      spike_volley <= '0;
      last         <= 1'b0;
    end else if (step_en) begin
      arrived      <= arrived_now;
      inh_latch    <= suppress;
      step         <= step + TW'(1);
      busy         <= !final_step;
      volley_valid <= 1'b1;
      spike_volley <= fire;
      time_val     <= step;
      last         <= final_step;
    end else begin
      // time_val deliberately holds its last value while idle.
      volley_valid <= 1'b0;
      spike_volley <= '0;
      last         <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    neuron_body #(
      .NUM_INPUTS (NUM_INPUTS),
      .WEIGHT_W   (WEIGHT_W),
      .THRESHOLD  (THRESHOLD)
    ) u_body (
      .clk      (clk),
      .rst_l    (rst_l),
      .arrived  (arrived_now),
      .weights  (w_q[w_lsb(g, 0, NUM_INPUTS, WEIGHT_W) +: NW]),
      .clear    (clear),
      .step_en  (step_en),
      .suppress (suppress),
      .fire     (fire[g])
    );
  end

endmodule

// File: tb/tb_neuron_column_integrator.sv
// Scoreboard bench: a closed-form potential model predicts each volley; a monitor compares.
module tb_neuron_column_integrator;

  localparam int TP = 8;
  localparam int NI = 4;
  localparam int NN = 4;
  localparam int WW = 3;
  localparam int TH = 8;
  localparam int TW = $clog2(TP) + 1;

  logic                  clk = 1'b0;
  logic                  rst_l;
  logic                  start;
  logic [NI-1:0]         in_spikes;
  logic [NN*NI*WW-1:0]   weights;
  logic                  inhibit;
  logic                  busy;
  logic                  volley_valid;
  logic [NN-1:0]         spike_volley;
  logic [TW-1:0]         time_val;
  logic                  last;

  always #5 clk = ~clk;

  neuron_column_integrator #(
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .TIME_PERIOD (TP),
    .WEIGHT_W    (WW),
    .THRESHOLD   (TH)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .start        (start),
    .in_spikes    (in_spikes),
    .weights      (weights),
    .inhibit      (inhibit),
    .busy         (busy),
    .volley_valid (volley_valid),
    .spike_volley (spike_volley),
    .time_val     (time_val),
    .last         (last)
  );

  typedef struct packed {
    logic [NN-1:0] sv;
    logic [TW-1:0] tv;
    logic          lst;
  } exp_t;

  exp_t          q[$];
  exp_t          got;
  int            checks   = 0;
  int            failures = 0;
  int            stim_w[NN][NI];
  logic [NI-1:0] stim_sp[TP];
  logic          stim_inh[TP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Potential at step t is sum over synapses of min(weight, steps since arrival).
  task automatic model_push();
    int   arr[NI];
    int   ih;
    int   pot;
    int   ramp;
    bit   fired[NN];
    exp_t e;
    ih = TP;
    for (int i = 0; i < NI; i++) arr[i] = TP;
    for (int n = 0; n < NN; n++) fired[n] = 1'b0;
    for (int t = 0; t < TP; t++) if (stim_inh[t] && ih == TP) ih = t;
    for (int t = 0; t < TP; t++) begin
      for (int i = 0; i < NI; i++) if (arr[i] == TP && stim_sp[t][i]) arr[i] = t;
      e.sv = '0;
      for (int n = 0; n < NN; n++) begin
        pot = 0;
        for (int i = 0; i < NI; i++) begin
          if (t >= arr[i]) begin
            ramp = t - arr[i] + 1;
            pot += (stim_w[n][i] < ramp) ? stim_w[n][i] : ramp;
          end
        end
        if (!fired[n] && t < ih && pot >= TH) begin
          fired[n] = 1'b1;
          e.sv[n]  = 1'b1;
        end
      end
      e.tv  = TW'(t);
      e.lst = (t == TP - 1);
      q.push_back(e);
    end
  endtask

  task automatic clear_stim();
    for (int n = 0; n < NN; n++) for (int i = 0; i < NI; i++) stim_w[n][i] = 0;
    for (int t = 0; t < TP; t++) begin
      stim_sp[t]  = '0;
      stim_inh[t] = 1'b0;
    end
  endtask

  task automatic set_single_fire();
    clear_stim();
    stim_w[0][0] = 7;
    stim_w[0][1] = 7;
    stim_sp[0]   = 4'b0011;
  endtask

  // Caller raises start before entry; returns 1 time unit after the last-volley edge.
  task automatic gamma(input int abort_at);
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++)
        weights[(n*NI+i)*WW +: WW] = WW'(stim_w[n][i]);
    model_push();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_start_cycle", volley_valid, 0);
    in_spikes = stim_sp[0];
    inhibit   = stim_inh[0];
    for (int t = 0; t < TP; t++) begin
      if (t == abort_at) begin
        @(negedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, volley_valid, spike_volley, time_val, last}, 0);
        q.delete();
        in_spikes = '0;
        inhibit   = 1'b0;
        #1;
        rst_l = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      chk("valid_every_step", volley_valid, 1);
      if (t < TP - 1) begin
        in_spikes = stim_sp[t+1];
        inhibit   = stim_inh[t+1];
      end else begin
        in_spikes = '0;
        inhibit   = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_l) begin
      if (volley_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_volley: got time_val=%0d spikes=%b, required none", time_val, spike_volley);
        end else begin
          got = q.pop_front();
          chk("spike_volley", {28'd0, spike_volley}, {28'd0, got.sv});
          chk("time_val", {28'd0, time_val}, {28'd0, got.tv});
          chk("last", last, got.lst);
          chk("busy_vs_last", busy, !got.lst);
        end
      end else begin
        chk("idle_volley_zero", {spike_volley, last}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l     = 1'b0;
    start     = 1'b0;
    in_spikes = '0;
    inhibit   = 1'b0;
    weights   = '0;
    clear_stim();
    #3;
    chk("reset_outputs", {busy, volley_valid, spike_volley, time_val, last}, 0);
    #9;
    rst_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", {busy, volley_valid, spike_volley, time_val, last}, 0);

    // Single neuron fires once at step 3, then back-to-back repeat.
    set_single_fire();
    start = 1'b1;
    gamma(-1);
    start = 1'b1;
    gamma(-1);
    repeat (2) @(posedge clk);
    #1;

    // Inhibit at step 4 blocks neuron1's step-5 firing.
    clear_stim();
    stim_w[0][0] = 7;
    stim_w[0][1] = 7;
    stim_w[1][0] = 7;
    stim_w[1][2] = 7;
    stim_sp[0]   = 4'b0011;
    stim_sp[3]   = 4'b0100;
    stim_inh[4]  = 1'b1;
    start = 1'b1;
    gamma(-1);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-run, then a clean gamma cycle.
    set_single_fire();
    start = 1'b1;
    gamma(4);
    start = 1'b1;
    gamma(-1);

    for (int r = 0; r < 24; r++) begin
      clear_stim();
      for (int n = 0; n < NN; n++)
        for (int i = 0; i < NI; i++) stim_w[n][i] = $urandom_range(0, 7);
      for (int t = 0; t < TP; t++)
        for (int i = 0; i < NI; i++) stim_sp[t][i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) stim_inh[$urandom_range(0, TP-1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      start = 1'b1;
      gamma(-1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
